fp_to_int_fsm: RTL

FP_TO_INT_FSM -- requirements
Module: fp_to_int_fsm

---
 rtl/fp_to_int_fsm.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fp_to_int_fsm.sv
// Multi-cycle IEEE-754 single-precision to int32 converter.
// One conversion per start; results appear four edges after the start edge.
module fp_to_int_fsm (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] Op_A_in,
    output logic [31:0] data_out,
    output logic [3:0]  status_out,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {StIdle, StDecode, StShift, StSign, StFinalize} state_e;
    typedef enum logic [1:0] {ClsNormal, ClsSmall, ClsLarge, ClsSpecial} cls_e;

    localparam logic [3:0]  StatExact    = 4'b0001;
    localparam logic [3:0]  StatOverflow = 4'b0010;
    localparam logic [3:0]  StatInexact  = 4'b0100;
    localparam logic [3:0]  StatInvalid  = 4'b1000;
    localparam logic [31:0] IntMax       = 32'h7FFF_FFFF;
    localparam logic [31:0] IntMin       = 32'h8000_0000;

    state_e      state_q, state_d;
    logic        sign_q;
    logic [7:0]  exp_q;
    logic [22:0] mant_q;
    cls_e        cls_q, cls_d;
    logic [54:0] mag_q, mag_d;
    logic        inexact_q, inexact_d;
    logic [31:0] res_q, res_d;
    logic [3:0]  stat_q, stat_d;
    logic [31:0] data_out_q;
    logic [3:0]  status_out_q;
    logic        done_q;

    logic [54:0] base;
    logic [7:0]  lsh, rsh;

    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (start) state_d = StDecode;
            StDecode:   state_d = StShift;
            StShift:    state_d = StSign;
            StSign:     state_d = StFinalize;
            StFinalize: state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        cls_d = ClsNormal;
        if (exp_q == 8'hFF)        cls_d = ClsSpecial;
        else if (exp_q < 8'd127)   cls_d = ClsSmall;
        else if (exp_q >= 8'd158)  cls_d = ClsLarge;
    end

    // exp 150 means E = 23: the mantissa already sits at the integer point.
    always_comb begin
        base      = {31'd0, 1'b1, mant_q};
        lsh       = exp_q - 8'd150;
        rsh       = 8'd150 - exp_q;
        mag_d     = '0;
        inexact_d = 1'b0;
        if (exp_q >= 8'd150) begin
            mag_d = base << lsh;
        end else begin
            mag_d     = base >> rsh;
            inexact_d = |(base[23:0] & ((24'd1 << rsh) - 24'd1));
        end
    end

    always_comb begin
        res_d  = '0;
        stat_d = StatExact;
        unique case (cls_q)
            ClsSpecial: begin
                res_d  = (mant_q != '0 || sign_q) ? IntMin : IntMax;
                stat_d = StatInvalid;
            end
            ClsSmall: begin
                res_d  = '0;
                stat_d = (exp_q == 8'd0 && mant_q == '0) ? StatExact : StatInexact;
            end
            ClsLarge: begin
                // -2^31 is the only E>=31 value that is representable.
                if (sign_q && exp_q == 8'd158 && mant_q == '0) begin
                    res_d  = IntMin;
                    stat_d = StatExact;
                end else begin
                    res_d  = sign_q ? IntMin : IntMax;
                    stat_d = StatOverflow;
                end
            end
            default: begin
                if (|mag_q[54:31]) begin
                    res_d  = sign_q ? IntMin : IntMax;
                    stat_d = StatOverflow;
                end else begin
                    res_d  = sign_q ? -mag_q[31:0] : mag_q[31:0];
                    stat_d = inexact_q ? StatInexact : StatExact;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sign_q       <= 1'b0;
            exp_q        <= '0;
            mant_q       <= '0;
            cls_q        <= ClsNormal;
            mag_q        <= '0;
            inexact_q    <= 1'b0;
            res_q        <= '0;
            stat_q       <= '0;
            data_out_q   <= '0;
            status_out_q <= '0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        sign_q <= Op_A_in[31];
                        exp_q  <= Op_A_in[30:23];
                        mant_q <= Op_A_in[22:0];
                    end
                end
                StDecode: cls_q <= cls_d;
                StShift: begin
                    mag_q     <= mag_d;
                    inexact_q <= inexact_d;
                end
                StSign: begin
                    res_q  <= res_d;
                    stat_q <= stat_d;
                end
                StFinalize: begin
                    data_out_q   <= res_q;
                    status_out_q <= stat_q;
                    done_q       <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign data_out   = data_out_q;
    assign status_out = status_out_q;
    assign done       = done_q;
    assign busy       = (state_q != StIdle);

endmodule
